result_link_arbiter: RTL and testbench
======================================

RESULT_LINK_ARBITER -- requirements
Module: result_link_arbiter

Interface
REQ-001 SHALL have parameter NUM_SOURCES, default 4: number of decoder controllers sharing one output byte link; minimum 2.
REQ-002 SHALL have parameter FRAME_BYTES, default 27: fixed frame length per source (iteration count, cycle count hi/lo, correction payload); minimum 1.
REQ-003 SHALL have parameter TAG_BASE, default 8'hA0: base value of the source tag byte.
REQ-004 SHALL have clk input, 1 bit: clock; all state updates on rising edge.
REQ-005 SHALL have reset input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have src_data input, NUM_SOURCES*8 bits: byte of source i at bits [8i+7:8i].
REQ-007 SHALL have src_valid input, NUM_SOURCES bits: per-source byte valid.
REQ-008 SHALL have src_ready output, NUM_SOURCES bits: per-source byte accept.
REQ-009 SHALL have out_data output, 8 bits: link byte.
REQ-010 SHALL have out_valid output, 1 bit: link byte valid.
REQ-011 SHALL have out_ready input, 1 bit: link accept.
REQ-012 SHALL have busy output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have frames_sent output, 16 bits: count of completed frames, wraps 16'hFFFF -> 0.

Function
REQ-014 SHALL implement three states: IDLE, TAG, PAYLOAD.
REQ-015 SHALL, in IDLE with any src_valid high, register grant = first index with src_valid high, searching round-robin from (last_grant+1) mod NUM_SOURCES, and enter TAG next cycle.
REQ-016 SHALL, in IDLE, drive out_valid=0 and src_ready=0 for all sources.
REQ-017 SHALL, in TAG, drive out_valid=1, out_data=TAG_BASE+grant (8-bit sum), src_ready all 0.
REQ-018 SHALL, on TAG handshake (out_valid & out_ready), enter PAYLOAD with byte_count=0.
REQ-019 SHALL, in PAYLOAD, combinationally drive out_data=src_data[grant], out_valid=src_valid[grant], src_ready[grant]=out_ready; all other src_ready bits 0.
REQ-020 SHALL, on each PAYLOAD handshake, increment byte_count (width $clog2(FRAME_BYTES+1)).
REQ-021 SHALL, on the PAYLOAD handshake with byte_count==FRAME_BYTES-1, enter IDLE, set last_grant=grant, increment frames_sent, all in the same edge.
REQ-022 SHALL hold grant constant from TAG entry until return to IDLE, regardless of other src_valid changes.
REQ-023 SHALL stall (no count change, no state change) in PAYLOAD while the granted source has src_valid=0 or out_ready=0.
REQ-024 SHALL never assert src_ready for a source outside PAYLOAD or for a non-granted source.
REQ-025 SHALL add exactly one cycle from IDLE request detection to TAG out_valid; a back-to-back frame SHALL spend exactly one IDLE cycle between frames.
REQ-026 SHALL ignore src_valid of non-granted sources; their bytes remain pending unconsumed.
REQ-027 SHALL, per frame on the link, emit exactly 1+FRAME_BYTES bytes.

Reset
REQ-028 SHALL, on reset, set state=IDLE, byte_count=0, grant=0, last_grant=NUM_SOURCES-1 (source 0 highest priority first), frames_sent=0.
REQ-029 SHALL, with reset high, drive out_valid=0, src_ready=0, busy=0, out_data=0.
REQ-030 SHALL, on reset asserted mid-frame (TAG or PAYLOAD), abandon the frame without counting it and return to IDLE next cycle.

Verification
REQ-031 Single source: only src_valid[2] high, 27 bytes 0x01..0x1B, out_ready=1 -> link carries 0xA2, 0x01..0x1B; frames_sent=1; busy low one cycle later.
REQ-032 Contention: all four sources valid continuously from reset -> tag order 0xA0, 0xA1, 0xA2, 0xA3, 0xA0; each tag followed by exactly 27 bytes of that source only.
REQ-033 Backpressure: out_ready toggling 1,0 every cycle during payload -> no byte lost or duplicated; src_ready[grant] equals out_ready each cycle; frame takes 55 cycles after TAG.
REQ-034 Source stall: granted source drops src_valid for 5 cycles at byte 10 -> out_valid low for those 5 cycles, byte_count holds 10, grant unchanged though other sources valid.
REQ-035 Reset mid-frame: reset for 1 cycle at payload byte 13 of source 1 -> outputs zero during reset, frames_sent=0, next grant goes to lowest-index valid source (source 0 if valid).
REQ-036 Counter wrap: force 65536 frames with FRAME_BYTES=1 -> frames_sent returns to 0; each frame occupies exactly 3 cycles (IDLE, TAG, PAYLOAD) under continuous valid/ready.

Source files
------------

// File: rtl/result_link_arbiter.sv
// Round-robin arbiter that serialises fixed-length frames from several
// decoder controllers onto one byte link, prefixing each with a source tag.
module result_link_arbiter #(
  parameter int          NUM_SOURCES = 4,
  parameter int          FRAME_BYTES = 27,
  parameter logic [7:0]  TAG_BASE    = 8'hA0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SOURCES*8-1:0] src_data,
  input  logic [NUM_SOURCES-1:0]   src_valid,
  output logic [NUM_SOURCES-1:0]   src_ready,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [15:0]              frames_sent
);

  localparam int GW = $clog2(NUM_SOURCES);
  localparam int CW = $clog2(FRAME_BYTES + 1);
  localparam logic [GW:0]   NS   = (GW+1)'(NUM_SOURCES);
  localparam logic [CW-1:0] LAST = CW'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    TAG,
    PAYLOAD
  } state_t;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   pick;
  logic            found;
  logic [GW:0]     idx;
  logic [CW-1:0]   byte_count;
  logic [15:0]     frames_q;

  // Search starts one past the previous winner and wraps around.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      idx = {1'b0, last_grant} + (GW+1)'(k + 1);
      if (idx >= NS)
        idx = idx - NS;
      if (!found && src_valid[idx[GW-1:0]]) begin
        found = 1'b1;
        pick  = idx[GW-1:0];
      end
    end
  end

  // Link side is combinational from state; reset forces it quiet at once.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    src_ready = '0;
    if (!reset) begin
      case (state)
        TAG: begin
          out_valid = 1'b1;
          out_data  = TAG_BASE + 8'(grant);
        end
        PAYLOAD: begin
          out_valid        = src_valid[grant];
          out_data         = src_data[{grant, 3'b000} +: 8];
          src_ready[grant] = out_ready;
        end
        default: ;
      endcase
    end
  end

  assign busy        = !reset && (state != IDLE);
  assign frames_sent = frames_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      byte_count <= '0;
      grant      <= '0;
      last_grant <= GW'(NUM_SOURCES - 1);
      frames_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= pick;
            state <= TAG;
          end
        end
        TAG: begin
          if (out_ready) begin
            state      <= PAYLOAD;
            byte_count <= '0;
          end
        end
        PAYLOAD: begin
          if (src_valid[grant] && out_ready) begin
            byte_count <= byte_count + 1'b1;
            if (byte_count == LAST) begin
              state      <= IDLE;
              last_grant <= grant;
              frames_q   <= frames_q + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_link_arbiter.sv
// Scoreboard bench for result_link_arbiter: a 27-byte frame instance
// plus a 1-byte frame instance for frame cadence.
module tb_result_link_arbiter;

  localparam int         N      = 4;
  localparam int         FB     = 27;
  localparam logic [7:0] TB_TAG = 8'hA0;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N*8-1:0] src_data;
  logic [N-1:0]   src_valid = '0;
  logic [N-1:0]   src_ready;
  logic [7:0]     out_data;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           busy;
  logic [15:0]    frames_sent;

  logic [N*8-1:0] src_data2;
  logic [N-1:0]   src_valid2 = '0;
  logic [N-1:0]   src_ready2;
  logic [7:0]     out_data2;
  logic           out_valid2;
  logic           out_ready2 = 1'b1;
  logic           busy2;
  logic [15:0]    frames_sent2;

  result_link_arbiter #(
    .NUM_SOURCES(N), .FRAME_BYTES(FB), .TAG_BASE(TB_TAG)
  ) dut (
    .clk(clk), .reset(reset),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frames_sent(frames_sent)
  );

  result_link_arbiter #(
    .NUM_SOURCES(N), .FRAME_BYTES(1), .TAG_BASE(TB_TAG)
  ) dut_small (
    .clk(clk), .reset(reset),
    .src_data(src_data2), .src_valid(src_valid2), .src_ready(src_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .busy(busy2), .frames_sent(frames_sent2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         tag;
    int         gap;
  } item_t;

  item_t      sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] cnt[N];
  logic [7:0] mcnt[N];
  logic [N-1:0] hs_src = '0;
  logic [N-1:0] exp_rdy;
  bit         in_payload = 0;
  int         cur = 0;
  int         pay_cnt = 0;
  int         tag_cyc = 0;

  assign src_data2 = 32'h44332211;

  always_comb begin
    src_data = '0;
    for (int i = 0; i < N; i++)
      src_data[i*8 +: 8] = cnt[i];
  end

  // Source model: a byte is consumed on each handshake.
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < N; i++)
      if (hs_src[i]) cnt[i] = cnt[i] + 8'd1;
  end

  always @(negedge clk) begin
    item_t it;
    hs_src = src_valid & src_ready;
    if (!reset) begin
      exp_rdy = '0;
      if (in_payload && out_ready) exp_rdy = N'(1) << cur;
      checks++;
      if (src_ready !== exp_rdy) begin
        errors++;
        $display("FAIL src_ready: got %b, required %b", src_ready, exp_rdy);
      end
    end
    if (out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL link_extra: got byte %h, required no byte", out_data);
      end else begin
        it = sb.pop_front();
        if (out_data !== it.d) begin
          errors++;
          $display("FAIL link_byte: got %h, required %h", out_data, it.d);
        end
        if (it.tag) begin
          if (it.gap != 0) begin
            checks++;
            if (cyc - tag_cyc != it.gap) begin
              errors++;
              $display("FAIL tag_gap: got %0d, required %0d", cyc - tag_cyc, it.gap);
            end
          end
          tag_cyc    = cyc;
          cur        = int'(it.d - TB_TAG);
          in_payload = 1;
          pay_cnt    = 0;
        end else begin
          pay_cnt++;
          if (pay_cnt == FB) in_payload = 0;
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    src_valid = '0;
    out_ready = 1'b1;
    sb.delete();
    in_payload = 0;
    pay_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      cnt[i]  = 8'(i * 64);
      mcnt[i] = cnt[i];
    end
    reset = 1'b0;
  endtask

  task automatic push_frame(input int s, input int gap);
    item_t it;
    it.d = TB_TAG + 8'(s); it.tag = 1; it.gap = gap;
    sb.push_back(it);
    for (int k = 0; k < FB; k++) begin
      it.d = mcnt[s]; it.tag = 0; it.gap = 0;
      sb.push_back(it);
      mcnt[s] = mcnt[s] + 8'd1;
    end
  endtask

  task automatic wait_drain(input int limit, input string name);
    for (int k = 0; k < limit && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s drain: got %0d bytes pending, required 0", name, sb.size());
      sb.delete();
      in_payload = 0;
    end
  endtask

  task automatic wait_pay(input int n, input string name);
    int k;
    for (k = 0; k < 200 && !(in_payload && pay_cnt == n); k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (k >= 200) begin
      errors++;
      $display("FAIL %s wait: got %0d payload bytes, required %0d", name, pay_cnt, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    src_valid = '1;
    src_valid2 = '1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks += 5;
      if (out_valid !== 1'b0 || out_valid2 !== 1'b0) begin
        errors++;
        $display("FAIL rst_valid: got %b/%b, required 0/0", out_valid, out_valid2);
      end
      if (src_ready !== '0 || src_ready2 !== '0) begin
        errors++;
        $display("FAIL rst_ready: got %b/%b, required 0", src_ready, src_ready2);
      end
      if (busy !== 1'b0 || busy2 !== 1'b0) begin
        errors++;
        $display("FAIL rst_busy: got %b/%b, required 0/0", busy, busy2);
      end
      if (out_data !== 8'h00 || out_data2 !== 8'h00) begin
        errors++;
        $display("FAIL rst_data: got %h/%h, required 00", out_data, out_data2);
      end
      if (frames_sent !== 16'd0) begin
        errors++;
        $display("FAIL rst_frames: got %0d, required 0", frames_sent);
      end
    end
    src_valid2 = '0;
    do_reset();
  endtask

  task automatic test_single();
    cnt[2] = 8'h01;
    mcnt[2] = 8'h01;
    push_frame(2, 0);
    src_valid = 4'b0100;
    wait_drain(100, "single");
    src_valid = '0;
    checks += 2;
    if (frames_sent !== 16'd1) begin
      errors++;
      $display("FAIL single_frames: got %0d, required 1", frames_sent);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy: got %b, required 0", busy);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got %b, required 0", out_valid);
    end
  endtask

  task automatic test_contention();
    do_reset();
    push_frame(0, 0);
    push_frame(1, 29);
    push_frame(2, 29);
    push_frame(3, 29);
    push_frame(0, 29);
    src_valid = '1;
    wait_drain(400, "contention");
    src_valid = '0;
    checks++;
    if (frames_sent !== 16'd5) begin
      errors++;
      $display("FAIL contention_frames: got %0d, required 5", frames_sent);
    end
  endtask

  task automatic test_backpressure();
    int k;
    do_reset();
    push_frame(1, 0);
    src_valid = 4'b0010;
    out_ready = 1'b1;
    for (k = 0; k < 200 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
      out_ready = ~out_ready;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got %0d pending, required 0", sb.size());
      sb.delete();
      in_payload = 0;
    end
    src_valid = '0;
    out_ready = 1'b1;
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_busy: got %b, required 0", busy);
    end
    if (cyc - tag_cyc != 55) begin
      errors++;
      $display("FAIL bp_length: got %0d, required 55", cyc - tag_cyc);
    end
  endtask

  task automatic test_stall();
    do_reset();
    push_frame(0, 0);
    push_frame(1, 34);
    src_valid = '1;
    wait_pay(10, "stall");
    src_valid[0] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks += 2;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_valid: got %b, required 0", out_valid);
      end
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_busy: got %b, required 1", busy);
      end
    end
    @(posedge clk);
    #1;
    src_valid[0] = 1'b1;
    wait_drain(200, "stall");
    src_valid = '0;
    checks++;
    if (frames_sent !== 16'd2) begin
      errors++;
      $display("FAIL stall_frames: got %0d, required 2", frames_sent);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_frame(1, 0);
    src_valid = 4'b0010;
    wait_pay(13, "rstmid");
    reset = 1'b1;
    sb.delete();
    in_payload = 0;
    src_valid = 4'b0011;
    @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b0 || src_ready !== '0) begin
      errors++;
      $display("FAIL rstmid_out: got v=%b r=%b, required 0", out_valid, src_ready);
    end
    if (out_data !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_data: got %h, required 00", out_data);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_busy: got %b, required 0", busy);
    end
    if (cnt[1] !== 8'h4D) begin
      errors++;
      $display("FAIL rstmid_consumed: got %h, required 4d", cnt[1]);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    mcnt[0] = cnt[0];
    mcnt[1] = cnt[1];
    push_frame(0, 0);
    push_frame(1, 29);
    @(negedge clk);
    checks++;
    if (frames_sent !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_frames: got %0d, required 0", frames_sent);
    end
    wait_drain(200, "rstmid");
    src_valid = '0;
    checks++;
    if (frames_sent !== 16'd2) begin
      errors++;
      $display("FAIL rstmid_after: got %0d, required 2", frames_sent);
    end
  endtask

  task automatic test_small_frames();
    logic [15:0] exp;
    int k;
    checks++;
    if (frames_sent2 !== 16'd0) begin
      errors++;
      $display("FAIL small_start: got %0d, required 0", frames_sent2);
    end
    src_valid2 = '1;
    for (k = 0; k < 20 && frames_sent2 == 16'd0; k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (frames_sent2 !== 16'd1) begin
      errors++;
      $display("FAIL small_first: got %0d, required 1", frames_sent2);
    end
    exp = 16'd1;
    repeat (6) begin
      repeat (3) @(posedge clk);
      #1;
      exp = exp + 16'd1;
      checks++;
      if (frames_sent2 !== exp) begin
        errors++;
        $display("FAIL small_period: got %0d, required %0d", frames_sent2, exp);
      end
    end
    src_valid2 = '0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy2 !== 1'b0 || out_valid2 !== 1'b0 || src_ready2 !== '0) begin
      errors++;
      $display("FAIL small_idle: got b=%b v=%b r=%b, required 0",
               busy2, out_valid2, src_ready2);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      cnt[i]  = '0;
      mcnt[i] = '0;
    end
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_small_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
